// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// DmemArbPkg
//   Shared types and constants for the data-memory arbiter.
//   - arb_state_e : priority state (CPU normally wins, DMA after bounded wait)
//   - port_sel_e  : which requester currently drives the RAM port
//   - cnt_width() : width of the wait/burst counters
// -----------------------------------------------------------------------------
package DmemArbPkg;

  localparam int DATA_WIDTH = 32;
  localparam int BE_WIDTH   = 4;

  typedef enum logic {CPU_PRI, DMA_PRI} arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CPU  = 2'd1,
    SEL_DMA  = 2'd2
  } port_sel_e;

  // Counters only ever compare against (max - 1), so one extra bit over the
  // log2 of the larger limit keeps the terminal value representable.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the CPU data port, the DMNI DMA port and the RAM port seen by
//   the arbiter. Signal names carry the direction as seen from the arbiter.
//   Modports:
//     slave  : the arbiter (takes requests, drives the RAM)
//     master : the surrounding PE (CPU, DMA and RAM)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 24
);
  import DmemArbPkg::*;

  // CPU port
  logic                  cpu_req_i;
  logic [BE_WIDTH-1:0]   cpu_we_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_data_i;
  logic                  cpu_stall_o;
  logic [DATA_WIDTH-1:0] cpu_data_o;

  // DMA port
  logic                  dma_req_i;
  logic [BE_WIDTH-1:0]   dma_we_i;
  logic [ADDR_WIDTH-1:0] dma_addr_i;
  logic [DATA_WIDTH-1:0] dma_data_i;
  logic                  dma_gnt_o;
  logic                  dma_rvalid_o;
  logic [DATA_WIDTH-1:0] dma_data_o;

  // RAM port
  logic                  mem_en_o;
  logic [BE_WIDTH-1:0]   mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_data_i,
    input  mem_data_i,
    output cpu_stall_o, cpu_data_o,
    output dma_gnt_o, dma_rvalid_o, dma_data_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output dma_req_i, dma_we_i, dma_addr_i, dma_data_i,
    output mem_data_i,
    input  cpu_stall_o, cpu_data_o,
    input  dma_gnt_o, dma_rvalid_o, dma_data_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the PE's single-port synchronous data memory between the RS5 CPU
//   data port and the DMNI DMA port. At most one access is granted per cycle;
//   the CPU loser sees cpu_stall_o, the DMA loser sees dma_gnt_o low. Read
//   data (1-cycle latency) is routed back to whoever issued the read.
//   The CPU normally wins contention; after DMA_MAX_WAIT lost contended
//   cycles the DMA gains priority for at most DMA_MAX_BURST contended cycles.
//
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset
//     bus     dmem_arbiter_if.slave (CPU, DMA and RAM ports)
// -----------------------------------------------------------------------------
module dmem_arbiter
  import DmemArbPkg::*;
#(
  parameter int ADDR_WIDTH    = 24,
  parameter int DMA_MAX_WAIT  = 4,
  parameter int DMA_MAX_BURST = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  dmem_arbiter_if.slave    bus
);

  localparam int CNT_W = cnt_width(DMA_MAX_WAIT, DMA_MAX_BURST);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(DMA_MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(DMA_MAX_BURST - 1);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic                  active_q;
  logic                  cpu_rd_q, dma_rd_q;

  logic                  cpu_gnt, dma_gnt, contend;
  port_sel_e             sel;
  logic [BE_WIDTH-1:0]   we_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] data_mux;

  // ---------------------------------------------------------------------------
  // Grant: combinational from the requests and the registered priority state.
  // Nothing is granted until the cycle after reset release (active_q).
  // ---------------------------------------------------------------------------
  assign contend = active_q & bus.cpu_req_i & bus.dma_req_i;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the block can leave a value unassigned and infer a latch.
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (active_q) begin
      if (state_q == CPU_PRI) begin
        cpu_gnt = bus.cpu_req_i;
        dma_gnt = bus.dma_req_i & ~bus.cpu_req_i;
      end else begin
        dma_gnt = bus.dma_req_i;
        cpu_gnt = bus.cpu_req_i & ~bus.dma_req_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port mux: driven by the granted requester, all zero when idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel = SEL_NONE;
    if (cpu_gnt)      sel = SEL_CPU;
    else if (dma_gnt) sel = SEL_DMA;
  end

  always_comb begin
    we_mux   = '0;
    addr_mux = '0;
    data_mux = '0;
    unique case (sel)
      SEL_CPU: begin
        we_mux   = bus.cpu_we_i;
        addr_mux = bus.cpu_addr_i;
        data_mux = bus.cpu_data_i;
      end
      SEL_DMA: begin
        we_mux   = bus.dma_we_i;
        addr_mux = bus.dma_addr_i;
        data_mux = bus.dma_data_i;
      end
      default: ;
    endcase
  end

  assign bus.mem_en_o   = cpu_gnt | dma_gnt;
  assign bus.mem_we_o   = we_mux;
  assign bus.mem_addr_o = addr_mux;
  assign bus.mem_data_o = data_mux;

  assign bus.cpu_stall_o = bus.cpu_req_i & ~cpu_gnt;
  assign bus.dma_gnt_o   = dma_gnt;

  // ---------------------------------------------------------------------------
  // Priority FSM and bounded-wait counters. Both counters return to zero at
  // their terminal compare, so they never wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    burst_cnt_d = burst_cnt_q;

    unique case (state_q)
      CPU_PRI: begin
        if (contend) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d    = DMA_PRI;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else if (dma_gnt) begin
          wait_cnt_d = '0;
        end
      end

      DMA_PRI: begin
        if (dma_gnt) wait_cnt_d = '0;
        // DMA gave up its slot: hand priority straight back to the CPU, which
        // is already granted this cycle by the grant logic above.
        if (active_q && !bus.dma_req_i) begin
          state_d     = CPU_PRI;
          burst_cnt_d = '0;
        end else if (contend) begin
          if (burst_cnt_q == BURST_LAST) begin
            state_d     = CPU_PRI;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = CPU_PRI;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CPU_PRI;
      wait_cnt_q  <= '0;
      burst_cnt_q <= '0;
      active_q    <= 1'b0;
      cpu_rd_q    <= 1'b0;
      dma_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      active_q    <= 1'b1;
      cpu_rd_q    <= cpu_gnt & (bus.cpu_we_i == '0);
      dma_rd_q    <= dma_gnt & (bus.dma_we_i == '0);
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: the RAM answers one cycle after enable; the registered read
  // flags steer that data to its issuer and zero the other port.
  // ---------------------------------------------------------------------------
  assign bus.dma_rvalid_o = dma_rd_q;
  assign bus.cpu_data_o   = cpu_rd_q ? bus.mem_data_i : '0;
  assign bus.dma_data_o   = dma_rd_q ? bus.mem_data_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter with a small behavioural RAM.
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(24)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH   (24),
    .DMA_MAX_WAIT (4),
    .DMA_MAX_BURST(2)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Behavioural single-port synchronous RAM (word indexed by addr[7:0]).
  logic [31:0] ram [256];
  bit          loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      ram[8'h10] <= 32'hDEADBEEF;
      ram[8'h04] <= 32'hAAAA0001;
      ram[8'h08] <= 32'hBBBB0002;
      loaded     <= 1'b1;
    end else if (bus.mem_en_o) begin
      if (bus.mem_we_o == 4'h0) begin
        bus.mem_data_i <= ram[bus.mem_addr_o[7:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_we_o[b]) ram[bus.mem_addr_o[7:0]][8*b +: 8] <= bus.mem_data_o[8*b +: 8];
      end
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic cr, input logic [3:0] cwe, input logic [23:0] ca,
                       input logic [31:0] cd, input logic dr, input logic [3:0] dwe,
                       input logic [23:0] da, input logic [31:0] dd);
    bus.cpu_req_i  = cr;
    bus.cpu_we_i   = cwe;
    bus.cpu_addr_i = ca;
    bus.cpu_data_i = cd;
    bus.dma_req_i  = dr;
    bus.dma_we_i   = dwe;
    bus.dma_addr_i = da;
    bus.dma_data_i = dd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Contention check: 1 = DMA expected to win this cycle, 0 = CPU.
  // CPU drives a write to 0x30, DMA a write/read to 0x40/0x08.
  task automatic check_winner(input string name, input bit dma_wins, input logic [23:0] dma_addr);
    @(negedge clk);
    check({name, " stall"}, {31'b0, bus.cpu_stall_o}, {31'b0, dma_wins});
    check({name, " gnt"},   {31'b0, bus.dma_gnt_o},   {31'b0, dma_wins});
    check({name, " addr"},  {8'b0, bus.mem_addr_o},   dma_wins ? {8'b0, dma_addr} : 32'h30);
  endtask

  typedef struct {
    logic        cr;    logic [3:0] cwe; logic [23:0] ca;    logic [31:0] cd;
    logic        dr;    logic [3:0] dwe; logic [23:0] da;    logic [31:0] dd;
    logic        stall; logic       gnt; logic        en;    logic [3:0]  mwe;
    logic [23:0] maddr; logic [31:0] mdata;
    logic [31:0] crd;   logic       rv;  logic [31:0] drd;
  } vec_t;

  vec_t vecs [10];

  bit seq_a [12];
  bit seq_b [5];
  bit seq_c [7];

  initial begin
    // cr cwe ca    cd  dr dwe da    dd             stall gnt en mwe maddr mdata          crd          rv drd
    vecs[0] = '{0, 0, 0,     0, 0, 0,   0,     0,            0, 0, 0, 0,   0,     0,            0,           0, 0};
    vecs[1] = '{1, 0, 'h10,  0, 0, 0,   0,     0,            0, 0, 1, 0,   'h10,  0,            0,           0, 0};
    vecs[2] = '{0, 0, 0,     0, 0, 0,   0,     0,            0, 0, 0, 0,   0,     0,            'hDEADBEEF,  0, 0};
    vecs[3] = '{0, 0, 0,     0, 1, 'hF, 'h20,  'h12345678,   0, 1, 1, 'hF, 'h20,  'h12345678,   0,           0, 0};
    vecs[4] = '{0, 0, 0,     0, 0, 0,   0,     0,            0, 0, 0, 0,   0,     0,            0,           0, 0};
    vecs[5] = '{1, 0, 'h4,   0, 0, 0,   0,     0,            0, 0, 1, 0,   'h4,   0,            0,           0, 0};
    vecs[6] = '{0, 0, 0,     0, 1, 0,   'h8,   0,            0, 1, 1, 0,   'h8,   0,            'hAAAA0001,  0, 0};
    vecs[7] = '{0, 0, 0,     0, 0, 0,   0,     0,            0, 0, 0, 0,   0,     0,            0,           1, 'hBBBB0002};
    vecs[8] = '{0, 0, 0,     0, 1, 0,   'h20,  0,            0, 1, 1, 0,   'h20,  0,            0,           0, 0};
    vecs[9] = '{0, 0, 0,     0, 0, 0,   0,     0,            0, 0, 0, 0,   0,     0,            0,           1, 'h12345678};

    seq_a = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
    seq_b = '{0, 0, 0, 0, 1};
    seq_c = '{0, 0, 0, 0, 1, 1, 0};

    // ---------------- reset with both requests pending ----------------
    drive(1, 4'h1, 24'h30, 32'h111, 1, 4'h2, 24'h40, 32'h222);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst mem_en",  {31'b0, bus.mem_en_o},     32'h0);
    check("rst dma_gnt", {31'b0, bus.dma_gnt_o},    32'h0);
    check("rst rvalid",  {31'b0, bus.dma_rvalid_o}, 32'h0);
    check("rst stall",   {31'b0, bus.cpu_stall_o},  32'h1);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rel mem_en", {31'b0, bus.mem_en_o},    32'h0);
    check("post-rel stall",  {31'b0, bus.cpu_stall_o}, 32'h1);
    next_cycle();

    // ---------------- table-driven single-owner vectors ----------------
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].cr, vecs[i].cwe, vecs[i].ca, vecs[i].cd,
            vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dd);
      @(negedge clk);
      check($sformatf("v%0d stall", i),  {31'b0, bus.cpu_stall_o},  {31'b0, vecs[i].stall});
      check($sformatf("v%0d gnt", i),    {31'b0, bus.dma_gnt_o},    {31'b0, vecs[i].gnt});
      check($sformatf("v%0d en", i),     {31'b0, bus.mem_en_o},     {31'b0, vecs[i].en});
      check($sformatf("v%0d mwe", i),    {28'b0, bus.mem_we_o},     {28'b0, vecs[i].mwe});
      check($sformatf("v%0d maddr", i),  {8'b0, bus.mem_addr_o},    {8'b0, vecs[i].maddr});
      check($sformatf("v%0d mdata", i),  bus.mem_data_o,            vecs[i].mdata);
      check($sformatf("v%0d cpu_rd", i), bus.cpu_data_o,            vecs[i].crd);
      check($sformatf("v%0d rvalid", i), {31'b0, bus.dma_rvalid_o}, {31'b0, vecs[i].rv});
      check($sformatf("v%0d dma_rd", i), bus.dma_data_o,            vecs[i].drd);
      next_cycle();
    end

    // ---------------- continuous contention: C,C,C,C,D,D repeating ----------------
    drive(1, 4'h1, 24'h30, 32'h111, 1, 4'h2, 24'h40, 32'h222);
    for (int i = 0; i < 12; i++) begin
      check_winner($sformatf("cont%0d", i), seq_a[i], 24'h40);
      next_cycle();
    end

    // ---------------- DMA drops its request after one priority grant ----------------
    for (int i = 0; i < 5; i++) begin
      check_winner($sformatf("pre-drop%0d", i), seq_b[i], 24'h40);
      next_cycle();
    end
    drive(1, 4'h1, 24'h30, 32'h111, 0, 4'h2, 24'h40, 32'h222);
    check_winner("drop", 1'b0, 24'h40);
    next_cycle();
    // Back in CPU_PRI with both counters cleared: full 4-wait / 2-burst again.
    drive(1, 4'h1, 24'h30, 32'h111, 1, 4'h2, 24'h40, 32'h222);
    for (int i = 0; i < 7; i++) begin
      check_winner($sformatf("post-drop%0d", i), seq_c[i], 24'h40);
      next_cycle();
    end

    // ---------------- uncontended DMA grant clears the wait count ----------------
    drive(0, 4'h0, 24'h0, 32'h0, 1, 4'h3, 24'h50, 32'h5555);
    @(negedge clk);
    check("clr gnt", {31'b0, bus.dma_gnt_o}, 32'h1);
    next_cycle();

    // ---------------- reset while a DMA read is in flight ----------------
    drive(1, 4'h1, 24'h30, 32'h111, 1, 4'h0, 24'h08, 32'h0);
    for (int i = 0; i < 5; i++) begin
      check_winner($sformatf("pre-rst%0d", i), seq_b[i], 24'h08);
      next_cycle();
    end
    check("inflight rvalid", {31'b0, bus.dma_rvalid_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst-mid rvalid", {31'b0, bus.dma_rvalid_o}, 32'h0);
    check("rst-mid mem_en", {31'b0, bus.mem_en_o},     32'h0);
    check("rst-mid gnt",    {31'b0, bus.dma_gnt_o},    32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel-mid mem_en", {31'b0, bus.mem_en_o},     32'h0);
    check("rel-mid stall",  {31'b0, bus.cpu_stall_o},  32'h1);
    check("rel-mid rvalid", {31'b0, bus.dma_rvalid_o}, 32'h0);
    next_cycle();
    // Priority is back with the CPU after reset.
    check_winner("after-rst", 1'b0, 24'h08);
    check("after-rst en", {31'b0, bus.mem_en_o}, 32'h1);
    next_cycle();

    drive(0, 4'h0, 24'h0, 32'h0, 0, 4'h0, 24'h0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
